arc4_seq: RTL and testbench
===========================

ARC4_SEQ -- requirements
Module: arc4_seq

Interface
REQ-001 SHALL have parameter: WDOG_CYCLES, 8192, max cycles any single phase may take before abort (range 16..65535).
REQ-002 SHALL have ports, clock and reset first; one clock, reset asynchronous and active-high:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  start request, sampled only while rdy=1.
- rdy  out  1  sequencer idle and able to accept en.
- key  in  24  ARC4 key, latched on accepted en.
- err  out  1  last run aborted by watchdog.
- init_en / init_rdy  out / in  1 / 1  init engine handshake.
- init_addr, init_wrdata / init_wren  in  8 / 1  init S-memory request.
- ksa_en / ksa_rdy  out / in  1 / 1  KSA engine handshake.
- ksa_key  out  24  latched key to KSA.
- ksa_addr, ksa_wrdata / ksa_wren  in  8 / 1  KSA S-memory request.
- prga_en / prga_rdy  out / in  1 / 1  PRGA engine handshake.
- prga_addr, prga_wrdata / prga_wren  in  8 / 1  PRGA S-memory request.
- s_addr, s_wrdata / s_wren  out  8 / 1  shared S-memory port.

Function
REQ-003 SHALL run phases strictly in order INIT, KSA, PRGA per accepted en; no overlap.
REQ-004 SHALL use states IDLE, INIT_GO, INIT_LO, INIT_HI, KSA_GO, KSA_LO, KSA_HI, PRGA_GO, PRGA_LO, PRGA_HI, ERR.
REQ-005 SHALL accept en when rdy=1 and en=1 at a clk edge: latch key, clear err, enter INIT_GO; rdy=0 from next cycle.
REQ-006 SHALL, in X_GO, drive x_en=x_rdy (combinational, single cycle) and move to X_LO when x_rdy=1.
REQ-007 SHALL move X_LO->X_HI when x_rdy=0, and X_HI->next phase GO (or IDLE after PRGA) when x_rdy=1.
REQ-008 SHALL hold every x_en at 0 outside its own X_GO state.
REQ-009 SHALL ignore en while rdy=0; a run is never aborted or restarted by en.
REQ-010 SHALL drive rdy=1 only in IDLE and ERR.
REQ-011 SHALL route s_addr/s_wrdata/s_wren from INIT in INIT_*, KSA in KSA_*, PRGA in PRGA_* states (combinational mux, zero latency).
REQ-012 SHALL drive s_addr=0, s_wrdata=0, s_wren=0 in IDLE and ERR; never high-impedance.
REQ-013 SHALL force s_wren=0 for any non-owning engine regardless of its request.
REQ-014 SHALL drive ksa_key from the latched key, stable for the whole run even if key changes.
REQ-015 SHALL complete a run: PRGA_HI with prga_rdy=1 -> IDLE, rdy=1 next cycle, err=0.

Reset
REQ-016 SHALL on rst=1, asynchronously: state IDLE, all x_en=0, s_wren=0, s_addr=0, s_wrdata=0, rdy=1 after release, err=0, latched key=0, watchdog count=0.
REQ-017 SHALL treat reset mid-run as full abort; no phase resumes after release.

Configuration
REQ-018 SHALL, with ARC4_SEQ_WDOG_EN defined: count cycles from entry to each X_GO, reload to 0 on every phase entry; on reaching WDOG_CYCLES enter ERR, err=1, all x_en=0, s_wren=0.
REQ-019 SHALL leave err set in ERR until the next accepted en; en in ERR restarts at INIT_GO.
REQ-020 SHALL, without ARC4_SEQ_WDOG_EN: omit counter logic, tie err=0, ERR unreachable; phases wait indefinitely.

Structure
REQ-021 SHALL place in package arc4_pkg: state enum arc4_seq_state_t, KEY_W=24, S_ADDR_W=8, WDOG_CYCLES_DEF=8192.
REQ-022 SHALL implement the watchdog as sub-module arc4_wdog (clear, tick, expired), instantiated only under ARC4_SEQ_WDOG_EN.

Verification
REQ-023 Normal run: key=24'h000318, engines ready after 1 cycle, busy 260/1030/520 cycles -> one pulse each on init_en, ksa_en, prga_en in order, ksa_key=24'h000318, rdy=1 one cycle after prga_rdy rises.
REQ-024 Mux isolation: KSA asserts ksa_wren=1, addr 8'h55 during INIT_* -> s_wren follows init_wren only, s_addr=init_addr; IDLE -> s_addr=0, s_wren=0.
REQ-025 Busy start: en=1 held during KSA, key changed to 24'hFFFFFF -> no restart, ksa_key stays 24'h000318, exactly one run.
REQ-026 Watchdog (macro on, WDOG_CYCLES=16): ksa_rdy held 0 after drop -> ERR 16 cycles after KSA_GO entry, err=1, rdy=1, s_wren=0; new en -> err=0, init_en pulses.
REQ-027 Reset mid-PRGA: rst=1 for 1 cycle -> immediate prga_en=0, s_wren=0; after release rdy=1, err=0, no engine enable until next en.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 phase sequencer.
// Holds the sequencer state encoding and the default watchdog limit.
package arc4_pkg;

    localparam int KEY_W           = 24;
    localparam int S_ADDR_W        = 8;
    localparam int WDOG_CYCLES_DEF = 8192;

    typedef enum logic [3:0] {
        IDLE,
        INIT_GO,
        INIT_LO,
        INIT_HI,
        KSA_GO,
        KSA_LO,
        KSA_HI,
        PRGA_GO,
        PRGA_LO,
        PRGA_HI,
        ERR
    } arc4_seq_state_t;

    // True for the single-cycle launch state of any phase.
    function automatic logic is_go(input arc4_seq_state_t st);
        return (st == INIT_GO) || (st == KSA_GO) || (st == PRGA_GO);
    endfunction

endpackage

// File: rtl/arc4_wdog.sv
// Phase watchdog for the ARC4 sequencer.
// Counts ticks since the last clear; 'expired' rises while the count sits
// at LIMIT-1, so a consumer that acts on it at the next edge does so
// exactly LIMIT cycles after the clear.
module arc4_wdog #(
    parameter int LIMIT = 8192
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int CW = 16;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired = (count_q == CW'(LIMIT - 1));

    // Next count: clear wins, otherwise advance until the limit is reached.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/arc4_seq.sv
// ARC4 phase sequencer: runs INIT, KSA and PRGA engines in order for each
// accepted start request and routes the owning engine onto the shared
// S-memory port.
// Optional feature: define ARC4_SEQ_WDOG_EN to add a per-phase watchdog
// that aborts a stuck run into ERR after WDOG_CYCLES cycles.
//
// Handshake: in X_GO the enable is a combinational copy of x_rdy, so the
// engine sees exactly one x_en=1 cycle; the engine then drops x_rdy while
// busy (X_LO waits for that) and raises it again when done (X_HI waits).
module arc4_seq
    import arc4_pkg::*;
#(
    parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic                rdy,
    input  logic [KEY_W-1:0]    key,
    output logic                err,
    output logic                init_en,
    input  logic                init_rdy,
    input  logic [S_ADDR_W-1:0] init_addr,
    input  logic [7:0]          init_wrdata,
    input  logic                init_wren,
    output logic                ksa_en,
    input  logic                ksa_rdy,
    output logic [KEY_W-1:0]    ksa_key,
    input  logic [S_ADDR_W-1:0] ksa_addr,
    input  logic [7:0]          ksa_wrdata,
    input  logic                ksa_wren,
    output logic                prga_en,
    input  logic                prga_rdy,
    input  logic [S_ADDR_W-1:0] prga_addr,
    input  logic [7:0]          prga_wrdata,
    input  logic                prga_wren,
    output logic [S_ADDR_W-1:0] s_addr,
    output logic [7:0]          s_wrdata,
    output logic                s_wren
);

    arc4_seq_state_t state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             start;

    assign start   = rdy && en;
    assign ksa_key = key_q;

`ifdef ARC4_SEQ_WDOG_EN
    logic wdog_clear;
    logic wdog_tick;
    logic wdog_expired;
    logic err_q, err_d;

    // Restart the count on every phase launch and keep it parked while idle.
    assign wdog_clear = ((state_d != state_q) && is_go(state_d))
                        || (state_q == IDLE) || (state_q == ERR);
    assign wdog_tick  = (state_q != IDLE) && (state_q != ERR);

    arc4_wdog #(
        .LIMIT (WDOG_CYCLES)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wdog_clear),
        .tick    (wdog_tick),
        .expired (wdog_expired)
    );

    // Error flag: set on entry to ERR, cleared by the next accepted start.
    always_comb begin
        err_d = err_q;
        if (start) begin
            err_d = 1'b0;
        end
        if ((state_d == ERR) && (state_q != ERR)) begin
            err_d = 1'b1;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic [15:0] wdog_unused;
    assign wdog_unused = 16'(WDOG_CYCLES);
    assign err         = 1'b0;
`endif

    // Next-state and handshake outputs; enables only ever assert in X_GO.
    always_comb begin
        state_d = state_q;
        rdy     = 1'b0;
        init_en = 1'b0;
        ksa_en  = 1'b0;
        prga_en = 1'b0;
        case (state_q)
            IDLE, ERR: begin
                rdy = 1'b1;
                if (en) state_d = INIT_GO;
            end
            INIT_GO: begin
                init_en = init_rdy;
                if (init_rdy) state_d = INIT_LO;
            end
            INIT_LO: if (!init_rdy) state_d = INIT_HI;
            INIT_HI: if (init_rdy)  state_d = KSA_GO;
            KSA_GO: begin
                ksa_en = ksa_rdy;
                if (ksa_rdy) state_d = KSA_LO;
            end
            KSA_LO:  if (!ksa_rdy)  state_d = KSA_HI;
            KSA_HI:  if (ksa_rdy)   state_d = PRGA_GO;
            PRGA_GO: begin
                prga_en = prga_rdy;
                if (prga_rdy) state_d = PRGA_LO;
            end
            PRGA_LO: if (!prga_rdy) state_d = PRGA_HI;
            PRGA_HI: if (prga_rdy)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef ARC4_SEQ_WDOG_EN
        if (wdog_expired && (state_q != IDLE) && (state_q != ERR)) begin
            state_d = ERR;
            init_en = 1'b0;
            ksa_en  = 1'b0;
            prga_en = 1'b0;
        end
`endif
    end

    // Key latch: captured only when a start request is accepted.
    always_comb begin
        key_d = key_q;
        if (start) key_d = key;
    end

    // State and latched key registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
        end
    end

    // Shared S-memory mux: the phase owning the current state drives it,
    // everything else (including IDLE and ERR) sees a quiet, zero port.
    always_comb begin
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;
        case (state_q)
            INIT_GO, INIT_LO, INIT_HI: begin
                s_addr   = init_addr;
                s_wrdata = init_wrdata;
                s_wren   = init_wren;
            end
            KSA_GO, KSA_LO, KSA_HI: begin
                s_addr   = ksa_addr;
                s_wrdata = ksa_wrdata;
                s_wren   = ksa_wren;
            end
            PRGA_GO, PRGA_LO, PRGA_HI: begin
                s_addr   = prga_addr;
                s_wrdata = prga_wrdata;
                s_wren   = prga_wren;
            end
            default: begin
                s_addr   = '0;
                s_wrdata = '0;
                s_wren   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_arc4_seq.sv
// Bench for arc4_seq: engine models with configurable busy time, an
// enable-order scoreboard, a table of S-memory mux vectors and hand-written
// sequences for busy start, watchdog/stall and reset mid-run.
module tb_arc4_seq;

    localparam int HOLD = 1000000;
`ifdef ARC4_SEQ_WDOG_EN
    localparam int LEN0 = 5;
    localparam int LEN1 = 9;
    localparam int LEN2 = 7;
`else
    localparam int LEN0 = 260;
    localparam int LEN1 = 1030;
    localparam int LEN2 = 520;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic        err;
    logic        init_en, init_rdy, init_wren;
    logic [7:0]  init_addr, init_wrdata;
    logic        ksa_en, ksa_rdy, ksa_wren;
    logic [23:0] ksa_key;
    logic [7:0]  ksa_addr, ksa_wrdata;
    logic        prga_en, prga_rdy, prga_wren;
    logic [7:0]  prga_addr, prga_wrdata;
    logic [7:0]  s_addr, s_wrdata;
    logic        s_wren;
    logic [2:0]  xen;

    always #5 clk = ~clk;
    assign xen = {prga_en, ksa_en, init_en};

    arc4_seq #(.WDOG_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy), .key(key), .err(err),
        .init_en(init_en), .init_rdy(init_rdy), .init_addr(init_addr),
        .init_wrdata(init_wrdata), .init_wren(init_wren),
        .ksa_en(ksa_en), .ksa_rdy(ksa_rdy), .ksa_key(ksa_key),
        .ksa_addr(ksa_addr), .ksa_wrdata(ksa_wrdata), .ksa_wren(ksa_wren),
        .prga_en(prga_en), .prga_rdy(prga_rdy), .prga_addr(prga_addr),
        .prga_wrdata(prga_wrdata), .prga_wren(prga_wren),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [1:0]  exp_q[$];
    logic [23:0] exp_key = '0;
    int          busy[3];
    int          busy_len[3];

    typedef struct {
        logic [1:0] phase;
        logic [7:0] ia; logic [7:0] id; logic iw;
        logic [7:0] ka; logic [7:0] kd; logic kw;
        logic [7:0] pa; logic [7:0] pd; logic pw;
        logic [7:0] ea; logic [7:0] ed; logic ew;
    } mux_vec_t;
    mux_vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Engine models: idle engines are ready; an enable makes them busy for
    // busy_len cycles.
    initial begin
        init_rdy = 1'b0; ksa_rdy = 1'b0; prga_rdy = 1'b0;
        for (int k = 0; k < 3; k++) busy[k] = 0;
        busy_len[0] = LEN0; busy_len[1] = LEN1; busy_len[2] = LEN2;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (busy[k] > 0) busy[k]--;
                if (xen[k]) busy[k] = busy_len[k];
            end
            @(posedge clk);
            #1;
            init_rdy = (busy[0] == 0) && !rst;
            ksa_rdy  = (busy[1] == 0) && !rst;
            prga_rdy = (busy[2] == 0) && !rst;
        end
    end

    // Scoreboard: each observed enable pulse must match the next expected phase.
    always @(negedge clk) begin
        if (!rst && (xen != 3'b000)) begin
            check("en_onehot", 32'($countones(xen)), 32'd1);
            if (exp_q.size() == 0) begin
                check("unexpected_en", {29'd0, xen}, 32'd0);
            end else begin
                logic [1:0] code;
                code = exp_q.pop_front();
                check("en_order", {29'd0, xen}, 32'(3'b001 << (code - 2'd1)));
            end
            if (ksa_en) check("ksa_key_at_en", {8'd0, ksa_key}, {8'd0, exp_key});
        end
    end

    task automatic start_run(input logic [23:0] k);
        @(posedge clk); #1;
        en = 1'b1; key = k; exp_key = k;
        exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic wait_en(input int k, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!xen[k] && n < budget);
        check($sformatf("wait_en%0d", k), {31'd0, xen[k]}, 32'd1);
    endtask

    task automatic wait_rdy(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy && n < budget);
        check("wait_rdy", {31'd0, rdy}, 32'd1);
    endtask

    // Move the held run from phase 'from' to phase 'to' (0 = idle).
    task automatic advance(input int from, input int to);
        if (from == 0) begin
            start_run(24'h000318);
            key = 24'hABCDEF;
            wait_en(0, 50);
        end else begin
            busy[from - 1] = 0;
            if (to == 0) wait_rdy(50);
            else wait_en(to - 1, 50);
        end
    endtask

    initial begin
        int cur;
        int k;
        rst = 1'b1; en = 1'b0; key = '0;
        init_addr = '0; init_wrdata = '0; init_wren = 1'b0;
        ksa_addr = '0; ksa_wrdata = '0; ksa_wren = 1'b0;
        prga_addr = '0; prga_wrdata = '0; prga_wren = 1'b0;

        //          ph     init               ksa                prga               expected
        vecs[0] = '{2'd0, 8'h11, 8'h22, 1'b1, 8'h33, 8'h44, 1'b1, 8'h55, 8'h66, 1'b1, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{2'd1, 8'h12, 8'h34, 1'b1, 8'h55, 8'hAA, 1'b1, 8'h77, 8'hBB, 1'b1, 8'h12, 8'h34, 1'b1};
        vecs[2] = '{2'd1, 8'h0F, 8'hF0, 1'b0, 8'h55, 8'hAA, 1'b1, 8'h77, 8'hBB, 1'b1, 8'h0F, 8'hF0, 1'b0};
        vecs[3] = '{2'd2, 8'h12, 8'h34, 1'b1, 8'h55, 8'hAA, 1'b1, 8'h66, 8'h77, 1'b1, 8'h55, 8'hAA, 1'b1};
        vecs[4] = '{2'd2, 8'h12, 8'h34, 1'b1, 8'h80, 8'h01, 1'b0, 8'h66, 8'h77, 1'b1, 8'h80, 8'h01, 1'b0};
        vecs[5] = '{2'd3, 8'h12, 8'h34, 1'b1, 8'h55, 8'hAA, 1'b1, 8'hFE, 8'hC9, 1'b1, 8'hFE, 8'hC9, 1'b1};
        vecs[6] = '{2'd3, 8'h12, 8'h34, 1'b1, 8'h55, 8'hAA, 1'b1, 8'h01, 8'h02, 1'b0, 8'h01, 8'h02, 1'b0};
        vecs[7] = '{2'd0, 8'h12, 8'h34, 1'b1, 8'h55, 8'hAA, 1'b1, 8'hFE, 8'hC9, 1'b1, 8'h00, 8'h00, 1'b0};
        vecs[8] = '{2'd0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0};

        // Reset state, during and just after reset.
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy", {31'd0, rdy}, 32'd1);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_xen", {29'd0, xen}, 32'd0);
        check("rst_s_wren", {31'd0, s_wren}, 32'd0);
        check("rst_s_addr", {24'd0, s_addr}, 32'd0);
        check("rst_ksa_key", {8'd0, ksa_key}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rdy", {31'd0, rdy}, 32'd1);
        repeat (2) @(negedge clk);

        // Mux isolation table with every engine held busy until released.
        for (int j = 0; j < 3; j++) busy_len[j] = HOLD;
        cur = 0;
        for (int i = 0; i < 9; i++) begin
            if (int'(vecs[i].phase) != cur) begin
                advance(cur, int'(vecs[i].phase));
                cur = int'(vecs[i].phase);
            end
            @(posedge clk); #1;
            init_addr = vecs[i].ia; init_wrdata = vecs[i].id; init_wren = vecs[i].iw;
            ksa_addr  = vecs[i].ka; ksa_wrdata  = vecs[i].kd; ksa_wren  = vecs[i].kw;
            prga_addr = vecs[i].pa; prga_wrdata = vecs[i].pd; prga_wren = vecs[i].pw;
            @(negedge clk);
            check($sformatf("mux%0d_addr", i), {24'd0, s_addr}, {24'd0, vecs[i].ea});
            check($sformatf("mux%0d_data", i), {24'd0, s_wrdata}, {24'd0, vecs[i].ed});
            check($sformatf("mux%0d_wren", i), {31'd0, s_wren}, {31'd0, vecs[i].ew});
            if (vecs[i].phase != 2'd0)
                check($sformatf("mux%0d_key", i), {8'd0, ksa_key}, 32'h000318);
        end
        check("mux_run_enables", 32'(exp_q.size()), 32'd0);
        busy_len[0] = LEN0; busy_len[1] = LEN1; busy_len[2] = LEN2;
        init_wren = 1'b0; ksa_wren = 1'b0; prga_wren = 1'b0;
        repeat (3) @(negedge clk);

        // Normal run: three ordered pulses, rdy one cycle after prga_rdy rises.
        start_run(24'h000318);
        key = 24'h123456;
        wait_en(2, 5000);
        k = 0;
        do begin @(negedge clk); k++; end while (prga_rdy && k < 10);
        k = 0;
        do begin @(negedge clk); k++; end while (!prga_rdy && k < 3000);
        check("prga_rdy_rise", {31'd0, prga_rdy}, 32'd1);
        check("rdy_before_done", {31'd0, rdy}, 32'd0);
        @(negedge clk);
        check("rdy_after_done", {31'd0, rdy}, 32'd1);
        check("err_after_done", {31'd0, err}, 32'd0);
        check("normal_enables", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);

        // Busy start: en held high and key changed during KSA.
        start_run(24'h000318);
        wait_en(1, 1000);
        @(posedge clk); #1;
        en = 1'b1; key = 24'hFFFFFF;
        repeat (4) @(negedge clk);
        check("busy_ksa_key", {8'd0, ksa_key}, 32'h000318);
        check("busy_rdy", {31'd0, rdy}, 32'd0);
        wait_en(2, 5000);
        @(posedge clk); #1;
        en = 1'b0;
        wait_rdy(3000);
        repeat (10) @(negedge clk);
        check("busy_one_run", 32'(exp_q.size()), 32'd0);
        check("busy_idle_rdy", {31'd0, rdy}, 32'd1);

`ifdef ARC4_SEQ_WDOG_EN
        // Watchdog: KSA never finishes; ERR 16 cycles after KSA_GO entry.
        busy_len[1] = HOLD;
        ksa_wren = 1'b1; ksa_addr = 8'h55;
        start_run(24'h000318);
        wait_en(1, 100);
        k = 0;
        do begin @(negedge clk); k++; end while (!rdy && k < 100);
        check("wdog_latency", 32'(k), 32'd16);
        check("wdog_err", {31'd0, err}, 32'd1);
        check("wdog_s_wren", {31'd0, s_wren}, 32'd0);
        check("wdog_xen", {29'd0, xen}, 32'd0);
        check("wdog_pending", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        busy[1] = 0; busy_len[1] = LEN1; ksa_wren = 1'b0; ksa_addr = '0;
        repeat (2) @(negedge clk);
        start_run(24'h000318);
        @(negedge clk);
        check("wdog_err_cleared", {31'd0, err}, 32'd0);
        wait_rdy(200);
        check("wdog_rerun", 32'(exp_q.size()), 32'd0);
        check("wdog_rerun_err", {31'd0, err}, 32'd0);
`else
        // Stalled KSA without a watchdog: the run simply waits.
        busy_len[1] = HOLD;
        start_run(24'h000318);
        wait_en(1, 1000);
        repeat (40) @(negedge clk);
        check("stall_rdy", {31'd0, rdy}, 32'd0);
        check("stall_err", {31'd0, err}, 32'd0);
        busy[1] = 0; busy_len[1] = LEN1;
        wait_rdy(3000);
        check("stall_done", 32'(exp_q.size()), 32'd0);
        check("stall_done_err", {31'd0, err}, 32'd0);
`endif
        repeat (3) @(negedge clk);

        // Reset in the middle of PRGA.
        start_run(24'h000318);
        wait_en(2, 5000);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        prga_wren = 1'b1; prga_addr = 8'hC3; prga_wrdata = 8'h5A;
        @(negedge clk);
        check("prga_s_wren", {31'd0, s_wren}, 32'd1);
        check("prga_s_addr", {24'd0, s_addr}, 32'h0C3);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_prga_en", {31'd0, prga_en}, 32'd0);
        check("midrst_s_wren", {31'd0, s_wren}, 32'd0);
        check("midrst_s_addr", {24'd0, s_addr}, 32'd0);
        check("midrst_s_data", {24'd0, s_wrdata}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_rdy", {31'd0, rdy}, 32'd1);
        check("midrst_err", {31'd0, err}, 32'd0);
        check("midrst_key", {8'd0, ksa_key}, 32'd0);
        repeat (20) @(negedge clk);
        check("midrst_no_run", {29'd0, xen}, 32'd0);
        check("midrst_idle", {31'd0, rdy}, 32'd1);
        prga_wren = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
